// File: rtl/uart_tx_shift_reg.sv
// UART transmit output shift register.
// Captures a data word on load, frames it as start bit, data (LSB first) and stop bit, and
// moves the serial line on by one bit per shift. Baud timing and bit counting belong to the
// enclosing transmitter.
// Optional build macro UART_TX_SHIFT_REG_STATUS_EN adds the bits_left and idle status outputs.
module uart_tx_shift_reg #(
  parameter int unsigned DAT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic                                 shift,
  input  logic [DAT_WIDTH-1:0]                 data,
`ifdef UART_TX_SHIFT_REG_STATUS_EN
  output logic [$clog2(DAT_WIDTH+3)-1:0]       bits_left,
  output logic                                 idle,
`endif
  output logic                                 uart_tx
);

  localparam int unsigned FrameW = DAT_WIDTH + 2;

  logic [FrameW-1:0] frame_q, frame_d;

  // Next frame: load beats shift; a shift refills from the top with idle-high ones.
  always_comb begin
    frame_d = frame_q;
    if (load) begin
      frame_d = {1'b1, data, 1'b0};
    end else if (shift) begin
      frame_d = {1'b1, frame_q[FrameW-1:1]};
    end
  end

  // Frame register; reset forces the line idle-high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '1;
    end else begin
      frame_q <= frame_d;
    end
  end

  // The line comes straight from the frame's low flop, so it cannot glitch.
  assign uart_tx = frame_q[0];

`ifdef UART_TX_SHIFT_REG_STATUS_EN
  localparam int unsigned BitsW = $clog2(DAT_WIDTH + 3);
  localparam logic [BitsW-1:0] BitsLoad = BitsW'(DAT_WIDTH + 2);
  localparam logic [BitsW-1:0] BitsOne  = BitsW'(1);

  logic [BitsW-1:0] bits_left_q, bits_left_d;

  // Remaining-bit count: reloads on load, counts shifts down and saturates at zero.
  always_comb begin
    bits_left_d = bits_left_q;
    if (load) begin
      bits_left_d = BitsLoad;
    end else if (shift && (bits_left_q != '0)) begin
      bits_left_d = bits_left_q - BitsOne;
    end
  end

  // Remaining-bit counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_left_q <= '0;
    end else begin
      bits_left_q <= bits_left_d;
    end
  end

  assign bits_left = bits_left_q;
  assign idle      = (bits_left_q == '0);
`endif

endmodule

// File: tb/tb_uart_tx_shift_reg.sv
// Directed testbench for uart_tx_shift_reg (DAT_WIDTH = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_uart_tx_shift_reg;

  logic       clk;
  logic       rst;
  logic       load;
  logic       shift;
  logic [7:0] data;
  logic       uart_tx;
`ifdef UART_TX_SHIFT_REG_STATUS_EN
  logic [3:0] bits_left;
  logic       idle;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_shift_reg #(
    .DAT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .data     (data),
`ifdef UART_TX_SHIFT_REG_STATUS_EN
    .bits_left(bits_left),
    .idle     (idle),
`endif
    .uart_tx  (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] d, input logic with_shift);
    data  = d;
    load  = 1'b1;
    shift = with_shift;
    tick(1);
    load  = 1'b0;
    shift = 1'b0;
  endtask

  task automatic do_shift();
    shift = 1'b1;
    tick(1);
    shift = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp_bits);
`ifdef UART_TX_SHIFT_REG_STATUS_EN
    check({tag, "_bits"}, 16'(bits_left), 16'(exp_bits));
    check({tag, "_idle"}, 16'(idle), 16'(exp_bits == 4'd0));
`else
    if (exp_bits > 4'd10) $display("note: %s unexpected count", tag);
`endif
  endtask

  logic [9:0] seq_a5;
  logic [8:0] seq_0f;

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    shift = 1'b0;
    data  = 8'h00;
    seq_a5 = 10'b11_0100_1010;  // bit i = expected line level i: 0,1,0,1,0,0,1,0,1,1
    seq_0f = 9'b1_0000_1111;    // bit i: 1,1,1,1,0,0,0,0,1

    // Reset state.
    #2;
    check("reset_tx", 16'(uart_tx), 16'd1);
    check_status("reset", 4'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("post_reset_tx", 16'(uart_tx), 16'd1);

    // Full 0xA5 frame, one shift every 4 clocks.
    do_load(8'hA5, 1'b0);
    check_status("a5_load", 4'd10);
    for (int lvl = 0; lvl < 10; lvl++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("a5_l%0d_c%0d", lvl, c), 16'(uart_tx), 16'(seq_a5[lvl]));
        if (c < 3) tick(1);
      end
      if (lvl < 9) do_shift();
    end
    check_status("a5_stop", 4'd1);

    // Over-shift: line stays idle, counter saturates.
    for (int i = 0; i < 5; i++) begin
      do_shift();
      check($sformatf("over_%0d", i), 16'(uart_tx), 16'd1);
    end
    check_status("over", 4'd0);

    // Load and shift together: load wins.
    do_load(8'h00, 1'b1);
    check("sim_start", 16'(uart_tx), 16'd0);
    check_status("sim_load", 4'd10);
    for (int i = 0; i < 8; i++) begin
      do_shift();
      check($sformatf("sim_d%0d", i), 16'(uart_tx), 16'd0);
    end
    do_shift();
    check("sim_stop", 16'(uart_tx), 16'd1);

    // Reload mid-frame.
    do_load(8'hFF, 1'b0);
    check("rl_start1", 16'(uart_tx), 16'd0);
    for (int i = 0; i < 3; i++) begin
      do_shift();
      check($sformatf("rl_ff%0d", i), 16'(uart_tx), 16'd1);
    end
    do_load(8'h0F, 1'b0);
    check("rl_start2", 16'(uart_tx), 16'd0);
    check_status("rl_load", 4'd10);
    for (int i = 0; i < 9; i++) begin
      do_shift();
      check($sformatf("rl_0f_%0d", i), 16'(uart_tx), 16'(seq_0f[i]));
    end

    // Hold: no shift keeps the start bit on the line.
    do_load(8'h55, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i % 5 == 4) check($sformatf("hold_%0d", i), 16'(uart_tx), 16'd0);
    end
    check_status("hold", 4'd10);

    // Asynchronous reset mid-frame, asserted between edges.
    do_shift();
    do_shift();                       // line now carries data[1] of 0x55 = 0
    check("ar_pre", 16'(uart_tx), 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async", 16'(uart_tx), 16'd1);
    check_status("ar_async", 4'd0);
    data = 8'h00;
    load = 1'b1;                      // ignored while in reset
    tick(2);
    check("ar_load_ignored", 16'(uart_tx), 16'd1);
    load = 1'b0;
    #3;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("ar_idle_%0d", i), 16'(uart_tx), 16'd1);
    end
    check_status("ar_idle", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
